// File: rtl/jtag_pkg.sv
// Shared JTAG constants and the IR select bundle.
// Used by the TAP FSM, the IR controller and the DR mux.
package jtag_pkg;

  localparam int IR_WIDTH_DEF = 4;
  localparam int N_USER_DEF   = 4;
  localparam int N_USER_MAX   = 8;

  localparam logic [3:0] CAPTURE_VAL_DEF  = 4'b0101;
  localparam logic [3:0] OP_EXTEST_DEF    = 4'b0000;
  localparam logic [3:0] OP_IDCODE_DEF    = 4'b0001;
  localparam logic [3:0] OP_SAMPLE_DEF    = 4'b0010;
  localparam logic [3:0] OP_USER_BASE_DEF = 4'b1000;

  typedef struct packed {
    logic                  extest;
    logic                  idcode;
    logic                  sample;
    logic                  bypass;
    logic [N_USER_MAX-1:0] user;
  } ir_sel_t;

  localparam ir_sel_t SEL_RESET = '{
    extest: 1'b0,
    idcode: 1'b1,
    sample: 1'b0,
    bypass: 1'b0,
    user:   '0
  };

endpackage

// File: rtl/jtag_ir_decode.sv
// Registered opcode-to-select decoder; exactly one select is high.
// Unknown opcodes (including all-ones) select BYPASS.
module jtag_ir_decode
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = IR_WIDTH_DEF,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST    = IR_WIDTH'(OP_EXTEST_DEF),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(OP_IDCODE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE    = IR_WIDTH'(OP_SAMPLE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_USER_BASE = IR_WIDTH'(OP_USER_BASE_DEF),
  parameter int                  N_USER       = N_USER_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [IR_WIDTH-1:0] opcode,
  output ir_sel_t             sel
);

  logic [N_USER_MAX-1:0] usr;
  ir_sel_t               nxt;

  always_comb begin
    usr = '0;
    for (int k = 0; k < N_USER; k++) begin
      usr[k] = (opcode == IR_WIDTH'(int'(OP_USER_BASE) + k));
    end
    nxt = '0;
    unique case (1'b1)
      (opcode == OP_EXTEST): nxt.extest = 1'b1;
      (opcode == OP_IDCODE): nxt.idcode = 1'b1;
      (opcode == OP_SAMPLE): nxt.sample = 1'b1;
      (|usr):                nxt.user   = usr;
      default:               nxt.bypass = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= SEL_RESET;
    end else if (load) begin
      sel <= nxt;
    end
  end

endmodule

// File: rtl/jtag_ir_ctrl.sv
// Parametrised JTAG instruction register: capture/shift, update, decode.
// Optional IR_PARITY_EN adds a parity bit shifted in last and sticky IR_ERR.
module jtag_ir_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = IR_WIDTH_DEF,
  parameter logic [IR_WIDTH-1:0] CAPTURE_VAL  = IR_WIDTH'(CAPTURE_VAL_DEF),
  parameter logic [IR_WIDTH-1:0] OP_EXTEST    = IR_WIDTH'(OP_EXTEST_DEF),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(OP_IDCODE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE    = IR_WIDTH'(OP_SAMPLE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_USER_BASE = IR_WIDTH'(OP_USER_BASE_DEF),
  parameter int                  N_USER       = N_USER_DEF
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TLR,
  input  logic                CAPTURE_IR,
  input  logic                SHIFT_IR,
  input  logic                UPDATE_IR,
  input  logic                TDI,
  output logic                I_TDO,
  output logic [IR_WIDTH-1:0] LATCH_IR,
  output logic                SEL_EXTEST,
  output logic                SEL_IDCODE,
  output logic                SEL_SAMPLE,
  output logic                SEL_BYPASS,
  output logic [N_USER-1:0]   SEL_USER,
  output logic                IR_ERR
);

`ifdef IR_PARITY_EN
  localparam int SR_W = IR_WIDTH + 1;
`else
  localparam int SR_W = IR_WIDTH;
`endif

  logic [SR_W-1:0] sr;
  logic            rst;
  logic            par_ok;
  ir_sel_t         sel;
  logic            unused_sel;

  assign rst = TRST | TLR;

  always_ff @(posedge TCK) begin
    if (rst) begin
      sr <= '0;
    end else if (CAPTURE_IR) begin
      sr <= SR_W'(CAPTURE_VAL);
    end else if (SHIFT_IR) begin
      sr <= {TDI, sr[SR_W-1:1]};
    end
  end

`ifdef IR_PARITY_EN
  // Parity bit must equal the XOR of the opcode bits
  assign par_ok = ~(^sr);

  always_ff @(posedge TCK) begin
    if (rst) begin
      IR_ERR <= 1'b0;
    end else if (UPDATE_IR && !par_ok) begin
      IR_ERR <= 1'b1;
    end
  end
`else
  assign par_ok = 1'b1;
  assign IR_ERR = 1'b0;
`endif

  // Update uses the pre-shift SR even if SHIFT_IR is also high
  always_ff @(posedge TCK) begin
    if (rst) begin
      LATCH_IR <= OP_IDCODE;
    end else if (UPDATE_IR && par_ok) begin
      LATCH_IR <= sr[IR_WIDTH-1:0];
    end
  end

  always_ff @(negedge TCK) begin
    if (TRST) begin
      I_TDO <= 1'b0;
    end else begin
      I_TDO <= sr[0];
    end
  end

  jtag_ir_decode #(
    .IR_WIDTH     (IR_WIDTH),
    .OP_EXTEST    (OP_EXTEST),
    .OP_IDCODE    (OP_IDCODE),
    .OP_SAMPLE    (OP_SAMPLE),
    .OP_USER_BASE (OP_USER_BASE),
    .N_USER       (N_USER)
  ) u_dec (
    .clk    (TCK),
    .rst    (rst),
    .load   (UPDATE_IR & par_ok),
    .opcode (sr[IR_WIDTH-1:0]),
    .sel    (sel)
  );

  assign SEL_EXTEST = sel.extest;
  assign SEL_IDCODE = sel.idcode;
  assign SEL_SAMPLE = sel.sample;
  assign SEL_BYPASS = sel.bypass;
  assign SEL_USER   = sel.user[N_USER-1:0];
  assign unused_sel = ^sel.user;

endmodule
